mole_hit_scorer: RTL and testbench
==================================

Name: mole_hit_scorer

Overview:
Downstream consumer of the game-control FSM's game_in_progress and mole_clk outputs. Each mole_clk high period lights one pseudo-randomly chosen hole LED. The block edge-detects the player's hole buttons, scores hits and wrong presses, and keeps a saturating BCD score for the 7-segment display stage. The score clears at the start of each game and holds after game over.

Parameters:
NUM_HOLES, 8, number of holes / LEDs / buttons (2..16).
SCORE_DIGITS, 3, BCD digits of score; max score is all 9s.
MISS_PENALTY, 1, 1 = a wrong press decrements the score (floor 0); 0 = no score change on a wrong press.
LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
clk  input  1  system clock, 50 MHz.
reset_n  input  1  asynchronous active-low reset.
game_in_progress  input  1  level from the game FSM; synchronous to clk.
mole_clk  input  1  level from the game FSM; high = mole-up window.
hole_buttons  input  NUM_HOLES  debounced, synchronised button levels; 1 = pressed.
mole_leds  output  NUM_HOLES  one-hot active mole, or all zero.
score_bcd  output  4*SCORE_DIGITS  packed BCD score; digit 0 in bits [3:0].
hit_pulse  output  1  one-cycle strobe on each hit.
miss_pulse  output  1  one-cycle strobe on each wrong press.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; mole_leds=0; score_bcd=0; hit_pulse=0; miss_pulse=0.
  - lfsr=LFSR_SEED; prev_idx=0; all edge-detect registers=0.
- Edge detection:
  - gip_q, mole_q and btn_q[] register the previous input sample.
  - gip_rise = gip & ~gip_q; mole_rise = mole_clk & ~mole_q; mole_fall = ~mole_clk & mole_q.
  - btn_rise[i] = hole_buttons[i] & ~btn_q[i].
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle regardless of state, so the sequence depends on player timing. It never holds zero.
- Hole select, IW=$clog2(NUM_HOLES):
  - raw = lfsr[IW-1:0]; if raw >= NUM_HOLES then raw -= NUM_HOLES.
  - If raw == prev_idx then idx = (raw+1) wraps at NUM_HOLES.
  - idx is latched into cur_idx and prev_idx on the mole_rise that arms a mole.
- State machine (all outputs registered):
  - Priority 1, any state: gip==0 → IDLE; mole_leds=0 next cycle; score held.
  - IDLE: gip_rise → score_bcd cleared to 0, go DOWN. If mole_rise occurs in the same cycle, go ARMED directly with score 0.
  - DOWN: mole_leds=0. mole_rise → latch idx, go ARMED.
  - ARMED: mole_leds=onehot(cur_idx).
    - btn_rise[cur_idx] → hit: score+1, saturating at all 9s; hit_pulse=1 for one cycle; go WHACKED.
    - Otherwise, any btn_rise on another hole → miss_pulse=1; score-1 if MISS_PENALTY, floor 0; stay ARMED.
    - Correct and wrong rises in the same cycle → hit only, no miss.
    - Several wrong rises in one cycle → exactly one miss.
    - mole_fall with no hit → DOWN (mole escaped, no score change).
    - Hit and mole_fall in the same cycle → hit counts, go DOWN.
  - WHACKED: mole_leds=0; buttons ignored; mole_fall → DOWN.
  - Buttons are ignored in IDLE, DOWN and WHACKED.
- Latency:
  - Input sampled high at edge N → mole_leds/score/pulses change at edge N (visible in cycle N+1). Edge N is the first edge where mole_clk=1 and mole_q=0; the same rule applies to a button rise.
  - Score update and pulse occur on the same edge.
- BCD arithmetic:
  - Per-digit increment rolls 9→0 with carry; decrement rolls 0→9 with borrow.
  - Saturation and floor are checked on the whole value, before the update.
- A mid-operation reset returns everything to reset values immediately; the LFSR reseeds.

Decomposition:
- Package whack_a_mole_pkg:
  - scorer_state_t enum {IDLE, DOWN, ARMED, WHACKED} (logic [1:0]).
  - LFSR_TAPS = 16'hB400.
  - bcd function helpers are optional.
- Sub-module bcd_updown_counter:
  - Parameter DIGITS.
  - Ports: clk, reset_n, clr, inc, dec, q.
  - Saturates at max and floors at 0; clr has highest priority, then inc (inc wins over dec).

Test Plan:
- Reset/idle: reset_n low 3 cycles, then game_in_progress=0 with mole_clk toggling → mole_leds=0, score_bcd=0, no pulses.
- Hit path: start game, mole_clk rises, read the lit LED index k, pulse hole_buttons[k] for 2 cycles → hit_pulse exactly once, score_bcd=12'h001, mole_leds=0 until the next mole_rise.
- Wrong press, MISS_PENALTY=1: with score=12'h002, press a non-lit hole → miss_pulse once, score=12'h001. Pressing the same wrong hole again after release → score=12'h000. A third press → score stays 12'h000.
- Simultaneous: press the lit hole and two other holes in the same cycle → hit_pulse=1, miss_pulse=0, score +1.
- Saturation: preload via 999 hits (or force) → score=12'h999; one more hit → stays 12'h999 and hit_pulse still fires.
- Game over/restart: drop game_in_progress while ARMED → mole_leds=0 next cycle, score held. Raise it again → score=12'h000. Over 200 consecutive moles: no consecutive repeat of idx, and idx always < NUM_HOLES (also rerun with NUM_HOLES=6).

Source files
------------

// File: rtl/mole_hit_scorer_pkg.sv
// Shared types and LFSR helper for the whack-a-mole hit scorer.
package whack_a_mole_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DOWN    = 2'd1,
    ARMED   = 2'd2,
    WHACKED = 2'd3
  } scorer_state_t;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mole_hit_scorer_if.sv
// Game-side signal bundle: game FSM levels and buttons in, LEDs/score/strobes out.
interface mole_hit_scorer_if #(
  parameter int NUM_HOLES    = 8,
  parameter int SCORE_DIGITS = 3
);
  logic                      game_in_progress;
  logic                      mole_clk;
  logic [NUM_HOLES-1:0]      hole_buttons;
  logic [NUM_HOLES-1:0]      mole_leds;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic                      hit_pulse;
  logic                      miss_pulse;

  modport master (
    output game_in_progress, mole_clk, hole_buttons,
    input  mole_leds, score_bcd, hit_pulse, miss_pulse
  );

  modport slave (
    input  game_in_progress, mole_clk, hole_buttons,
    output mole_leds, score_bcd, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/mole_hit_scorer_bcd_updown_counter.sv
// Multi-digit BCD up/down counter; saturates at all 9s, floors at 0.
module bcd_updown_counter #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] q
);

  logic [4*DIGITS-1:0] r_q;
  logic [4*DIGITS-1:0] w_inc_val;
  logic [4*DIGITS-1:0] w_dec_val;
  logic                w_carry;
  logic                w_borrow;
  logic                w_max;
  logic                w_zero;

  // Ripple carry/borrow digit by digit; limits are judged on the whole value.
  always_comb begin
    w_inc_val = r_q;
    w_dec_val = r_q;
    w_carry   = 1'b1;
    w_borrow  = 1'b1;
    w_max     = 1'b1;
    w_zero    = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_q[4*d +: 4] != 4'd9) w_max = 1'b0;
      if (r_q[4*d +: 4] != 4'd0) w_zero = 1'b0;
      if (w_carry) begin
        if (r_q[4*d +: 4] == 4'd9) begin
          w_inc_val[4*d +: 4] = 4'd0;
        end else begin
          w_inc_val[4*d +: 4] = r_q[4*d +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_q[4*d +: 4] == 4'd0) begin
          w_dec_val[4*d +: 4] = 4'd9;
        end else begin
          w_dec_val[4*d +: 4] = r_q[4*d +: 4] - 4'd1;
          w_borrow            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      if (!w_max) r_q <= w_inc_val;
    end else if (dec) begin
      if (!w_zero) r_q <= w_dec_val;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: picks a hole per mole window, detects hits/misses, keeps a BCD score.
module mole_hit_scorer
  import whack_a_mole_pkg::*;
#(
  parameter int          NUM_HOLES    = 8,
  parameter int          SCORE_DIGITS = 3,
  parameter int          MISS_PENALTY = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic              clk,
  input logic              reset_n,
  mole_hit_scorer_if.slave io
);

  localparam int         IW      = $clog2(NUM_HOLES);
  localparam logic [IW:0] NH     = NUM_HOLES[IW:0];
  localparam int         NH_M1_I = NUM_HOLES - 1;
  localparam logic [IW:0] NH_M1  = NH_M1_I[IW:0];
  localparam logic [IW:0] ONE    = {{IW{1'b0}}, 1'b1};

  scorer_state_t        r_state;
  scorer_state_t        w_state_nxt;
  logic [15:0]          r_lfsr;
  logic                 r_gip_q;
  logic                 r_mole_q;
  logic [NUM_HOLES-1:0] r_btn_q;
  logic [IW:0]          r_cur_idx;
  logic [IW:0]          r_prev_idx;
  logic [NUM_HOLES-1:0] r_mole_leds;
  logic                 r_hit_pulse;
  logic                 r_miss_pulse;

  logic                 w_gip_rise;
  logic                 w_mole_rise;
  logic                 w_mole_fall;
  logic [NUM_HOLES-1:0] w_btn_rise;
  logic [IW:0]          w_raw;
  logic [IW:0]          w_idx;
  logic [IW:0]          w_cur_idx_nxt;
  logic [NUM_HOLES-1:0] w_cur_mask;
  logic [NUM_HOLES-1:0] w_arm_mask;
  logic [NUM_HOLES-1:0] w_leds_nxt;
  logic                 w_armed;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_arm;
  logic                 w_clr;
  logic                 w_inc;
  logic                 w_dec;

  assign w_gip_rise  = io.game_in_progress & ~r_gip_q;
  assign w_mole_rise = io.mole_clk & ~r_mole_q;
  assign w_mole_fall = ~io.mole_clk & r_mole_q;
  assign w_btn_rise  = io.hole_buttons & ~r_btn_q;

  // Fold the LFSR slice into range, then step off the previous hole.
  always_comb begin
    w_raw = {1'b0, r_lfsr[IW-1:0]};
    if (w_raw >= NH) w_raw = w_raw - NH;
    w_idx = w_raw;
    if (w_raw == r_prev_idx) w_idx = (w_raw == NH_M1) ? '0 : w_raw + ONE;
  end

  always_comb begin
    for (int i = 0; i < NUM_HOLES; i++) w_cur_mask[i] = (r_cur_idx == i[IW:0]);
  end

  // Correct-hole rise wins; any number of wrong rises makes a single miss.
  assign w_armed = io.game_in_progress & (r_state == ARMED);
  assign w_hit   = w_armed & (|(w_btn_rise & w_cur_mask));
  assign w_miss  = w_armed & ~w_hit & (|(w_btn_rise & ~w_cur_mask));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    if (!io.game_in_progress) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gip_rise) begin
            if (w_mole_rise) begin
              w_state_nxt = ARMED;
              w_arm       = 1'b1;
            end else begin
              w_state_nxt = DOWN;
            end
          end
        end
        DOWN: begin
          if (w_mole_rise) begin
            w_state_nxt = ARMED;
            w_arm       = 1'b1;
          end
        end
        ARMED: begin
          if (w_hit)            w_state_nxt = w_mole_fall ? DOWN : WHACKED;
          else if (w_mole_fall) w_state_nxt = DOWN;
        end
        WHACKED: begin
          if (w_mole_fall) w_state_nxt = DOWN;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cur_idx_nxt = w_arm ? w_idx : r_cur_idx;
    for (int i = 0; i < NUM_HOLES; i++) w_arm_mask[i] = (w_cur_idx_nxt == i[IW:0]);
    w_leds_nxt = (w_state_nxt == ARMED) ? w_arm_mask : '0;
    w_clr      = io.game_in_progress & w_gip_rise & (r_state == IDLE);
    w_inc      = w_hit;
    w_dec      = w_miss & (MISS_PENALTY != 0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr       <= LFSR_SEED;
      r_gip_q      <= 1'b0;
      r_mole_q     <= 1'b0;
      r_btn_q      <= '0;
      r_cur_idx    <= '0;
      r_prev_idx   <= '0;
      r_mole_leds  <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_lfsr       <= lfsr_next(r_lfsr);
      r_gip_q      <= io.game_in_progress;
      r_mole_q     <= io.mole_clk;
      r_btn_q      <= io.hole_buttons;
      r_cur_idx    <= w_cur_idx_nxt;
      if (w_arm) r_prev_idx <= w_idx;
      r_mole_leds  <= w_leds_nxt;
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
    end
  end

  bcd_updown_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .inc     (w_inc),
    .dec     (w_dec),
    .q       (io.score_bcd)
  );

  assign io.mole_leds  = r_mole_leds;
  assign io.hit_pulse  = r_hit_pulse;
  assign io.miss_pulse = r_miss_pulse;

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Self-checking bench: table of game steps plus saturation and mid-game reset sequences.
module tb_mole_hit_scorer;

  localparam int S_NONE   = 0;
  localparam int S_LIT    = 1;
  localparam int S_WRONG  = 2;
  localparam int S_MULTI  = 3;
  localparam int S_WRONG2 = 4;
  localparam int NVEC     = 36;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  mole_hit_scorer_if #(.NUM_HOLES(8), .SCORE_DIGITS(3)) bus8 ();
  mole_hit_scorer_if #(.NUM_HOLES(6), .SCORE_DIGITS(3)) bus6 ();

  assign bus6.game_in_progress = bus8.game_in_progress;
  assign bus6.mole_clk         = bus8.mole_clk;
  assign bus6.hole_buttons     = 6'b0;

  mole_hit_scorer #(.NUM_HOLES(8), .SCORE_DIGITS(3), .MISS_PENALTY(1), .LFSR_SEED(16'hACE1))
    dut8 (.clk(clk), .reset_n(reset_n), .io(bus8));
  mole_hit_scorer #(.NUM_HOLES(6), .SCORE_DIGITS(3), .MISS_PENALTY(1), .LFSR_SEED(16'hACE1))
    dut6 (.clk(clk), .reset_n(reset_n), .io(bus6));

  typedef struct {
    logic g;
    logic m;
    int   sel;
    int   score;
    logic hit;
    logic miss;
    logic lit;
  } vec_t;

  typedef struct {
    logic [7:0]  leds;
    logic [11:0] score;
    logic        hit;
    logic        miss;
    logic        arm;
    logic [5:0]  leds6;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_lfsr;
  int          m_idx8 = 0, m_prev8 = 0, m_idx6 = 0, m_prev6 = 0;
  logic        last_mole = 1'b0;
  logic [5:0]  last_leds6 = 6'b0;
  int          sc;

  // Reference LFSR, written bitwise from the polynomial taps.
  function automatic logic [15:0] model_step(input logic [15:0] l);
    logic [15:0] n;
    logic        fb;
    fb    = l[0];
    n     = {1'b0, l[15:1]};
    n[15] = fb;
    n[13] = l[14] ^ fb;
    n[12] = l[13] ^ fb;
    n[10] = l[11] ^ fb;
    return n;
  endfunction

  function automatic int model_sel(input logic [15:0] l, input int prev, input int n, input int iw);
    int raw;
    raw = int'(l) % (1 << iw);
    if (raw >= n) raw = raw - n;
    if (raw == prev) raw = (raw + 1) % n;
    return raw;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= model_step(m_lfsr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step(input logic g, input logic m, input int sel, input int score,
                      input logic eh, input logic em, input logic elit);
    exp_t       e;
    logic       arm;
    logic [7:0] lit;
    logic [7:0] btn;
    @(negedge clk);
    arm = m && !last_mole && elit;
    if (arm) begin
      m_idx8  = model_sel(m_lfsr, m_prev8, 8, 3);
      m_prev8 = m_idx8;
      m_idx6  = model_sel(m_lfsr, m_prev6, 6, 3);
      m_prev6 = m_idx6;
    end
    lit = 8'(1) << m_idx8;
    case (sel)
      S_LIT:    btn = lit;
      S_WRONG:  btn = 8'(1) << ((m_idx8 + 1) % 8);
      S_MULTI:  btn = lit | (8'(1) << ((m_idx8 + 1) % 8)) | (8'(1) << ((m_idx8 + 2) % 8));
      S_WRONG2: btn = (8'(1) << ((m_idx8 + 1) % 8)) | (8'(1) << ((m_idx8 + 2) % 8));
      default:  btn = 8'b0;
    endcase
    bus8.game_in_progress = g;
    bus8.mole_clk         = m;
    bus8.hole_buttons     = btn;
    last_mole             = m;
    e.leds  = elit ? lit : 8'b0;
    e.score = to_bcd(score);
    e.hit   = eh;
    e.miss  = em;
    e.arm   = arm;
    e.leds6 = 6'(1) << m_idx6;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("mole_leds",  32'(bus8.mole_leds),  32'(e.leds));
    check("score_bcd",  32'(bus8.score_bcd),  32'(e.score));
    check("hit_pulse",  32'(bus8.hit_pulse),  32'(e.hit));
    check("miss_pulse", 32'(bus8.miss_pulse), 32'(e.miss));
    check("score6",     32'(bus6.score_bcd),  32'(0));
    if (e.arm) begin
      check("leds6_arm", 32'(bus6.mole_leds), 32'(e.leds6));
      n_cmp++;
      if (bus6.mole_leds == last_leds6) begin
        n_bad++;
        $display("FAIL leds6_repeat: got %0h want not %0h", bus6.mole_leds, last_leds6);
      end
      last_leds6 = bus6.mole_leds;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, S_NONE,   0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, S_NONE,   0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, S_LIT,    1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, S_LIT,    1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, S_NONE,   1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, S_LIT,    2, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, S_NONE,   2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, S_NONE,   2, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, S_WRONG,  1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, S_WRONG,  0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, S_WRONG,  0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, S_WRONG2, 0, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 1'b0, S_NONE,   0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 1'b1, S_MULTI,  1, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b0, S_NONE,   1, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b1};
    vecs[26] = '{1'b0, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, S_NONE,   1, 1'b0, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 1'b0, S_NONE,   0, 1'b0, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[30] = '{1'b1, 1'b0, S_LIT,    1, 1'b1, 1'b0, 1'b0};
    vecs[31] = '{1'b1, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b1};
    vecs[32] = '{1'b1, 1'b1, S_NONE,   1, 1'b0, 1'b0, 1'b1};
    vecs[33] = '{1'b0, 1'b0, S_NONE,   1, 1'b0, 1'b0, 1'b0};
    vecs[34] = '{1'b1, 1'b1, S_NONE,   0, 1'b0, 1'b0, 1'b1};
    vecs[35] = '{1'b1, 1'b1, S_LIT,    1, 1'b1, 1'b0, 1'b0};

    bus8.game_in_progress = 1'b0;
    bus8.mole_clk         = 1'b0;
    bus8.hole_buttons     = 8'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds",  32'(bus8.mole_leds),  32'(0));
    check("rst_score", 32'(bus8.score_bcd),  32'(0));
    check("rst_hit",   32'(bus8.hit_pulse),  32'(0));
    check("rst_miss",  32'(bus8.miss_pulse), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < NVEC; v++)
      step(vecs[v].g, vecs[v].m, vecs[v].sel, vecs[v].score, vecs[v].hit, vecs[v].miss, vecs[v].lit);

    // Climb to the 999 ceiling, then one extra hit must still strobe.
    sc = 1;
    for (int k = 0; k < 999; k++) begin
      step(1'b1, 1'b0, S_NONE, sc, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, S_NONE, sc, 1'b0, 1'b0, 1'b1);
      sc = (sc < 999) ? sc + 1 : 999;
      step(1'b1, 1'b1, S_LIT, sc, 1'b1, 1'b0, 1'b0);
    end
    check("sat_score", 32'(bus8.score_bcd), 32'(12'h999));

    step(1'b1, 1'b0, S_NONE, 999, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, S_NONE, 999, 1'b0, 1'b0, 1'b1);

    // Reset while a mole is up: everything clears at once, LFSR reseeds.
    @(negedge clk);
    reset_n               = 1'b0;
    bus8.game_in_progress = 1'b0;
    bus8.mole_clk         = 1'b0;
    bus8.hole_buttons     = 8'b0;
    #1;
    check("mid_rst_leds",  32'(bus8.mole_leds),  32'(0));
    check("mid_rst_score", 32'(bus8.score_bcd),  32'(0));
    check("mid_rst_hit",   32'(bus8.hit_pulse),  32'(0));
    check("mid_rst_miss",  32'(bus8.miss_pulse), 32'(0));
    m_prev8    = 0;
    m_prev6    = 0;
    last_mole  = 1'b0;
    last_leds6 = 6'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, S_NONE, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, S_NONE, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, S_LIT,  1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
